// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider, one quotient bit per clock, start/finish handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             finish,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] r_dividend;
    logic             r_dz;
    logic             r_finish;
    logic             r_dz_out;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
`ifdef DIVIDER_SIGNED_EN
    logic             r_sa;
    logic             r_sb;
`endif

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_p_sh;
    logic [WIDTH:0]   w_p_new;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    // Operand magnitudes; |most-negative| still fits in WIDTH unsigned bits
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        w_a_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
        w_b_mag = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;
`else
        w_a_mag = dividend;
        w_b_mag = divisor;
`endif
    end

    // One non-restoring step; the add/subtract choice follows the sign of P before the shift
    always_comb begin
        w_p_sh  = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
        w_p_new = r_p[WIDTH] ? (w_p_sh + r_d) : (w_p_sh - r_d);
    end

    // Final remainder correction, sign application and divide-by-zero override
    always_comb begin
        w_r_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d[WIDTH-1:0]) : r_p[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
        w_quot  = (r_sa ^ r_sb) ? ({WIDTH{1'b0}} - r_q) : r_q;
        w_rem   = r_sa ? ({WIDTH{1'b0}} - w_r_mag) : w_r_mag;
`else
        w_quot  = r_q;
        w_rem   = w_r_mag;
`endif
        if (r_dz) begin
            w_quot = {WIDTH{1'b1}};
            w_rem  = r_dividend;
        end else begin
            w_quot = w_quot;
            w_rem  = w_rem;
        end
    end

    // Datapath and FSM; start aborts whatever is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_p         <= {(WIDTH+1){1'b0}};
            r_q         <= {WIDTH{1'b0}};
            r_d         <= {(WIDTH+1){1'b0}};
            r_dividend  <= {WIDTH{1'b0}};
            r_dz        <= 1'b0;
            r_quotient  <= {WIDTH{1'b0}};
            r_remainder <= {WIDTH{1'b0}};
`ifdef DIVIDER_SIGNED_EN
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
`endif
        end else if (start) begin
            r_state    <= S_ITER;
            r_cnt      <= CNT_INIT;
            r_p        <= {(WIDTH+1){1'b0}};
            r_q        <= w_a_mag;
            r_d        <= {1'b0, w_b_mag};
            r_dividend <= dividend;
            r_dz       <= (divisor == {WIDTH{1'b0}});
`ifdef DIVIDER_SIGNED_EN
            r_sa       <= dividend[WIDTH-1];
            r_sb       <= divisor[WIDTH-1];
`endif
        end else begin
            case (r_state)
                S_ITER: begin
                    r_p   <= w_p_new;
                    r_q   <= {r_q[WIDTH-2:0], ~w_p_new[WIDTH]};
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_FIX: begin
                    r_quotient  <= w_quot;
                    r_remainder <= w_rem;
                    r_state     <= S_DONE;
                end
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags trail the state by one edge so they drop on the edge after a restart
    always_ff @(posedge clk) begin
        if (rst) begin
            r_finish <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            r_finish <= (r_state == S_DONE);
            r_dz_out <= (r_state == S_DONE) & r_dz;
        end
    end

    assign finish      = r_finish;
    assign div_by_zero = r_dz_out;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed-vector bench for nonrestoring_divider (WIDTH=8); follows DIVIDER_SIGNED_EN like the RTL.
module tb_nonrestoring_divider;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    localparam int NV      = 11;
    localparam int LATENCY = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       finish;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[NV];

    nonrestoring_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .finish      (finish),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one division and count edges until finish, bounded
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!finish && lat < 40);
    endtask

    initial begin
        int lat;
        int ia, ib, iq, ir;
        logic [7:0] q0;
        logic [7:0] r0;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] recon;

`ifdef DIVIDER_SIGNED_EN
        vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
        vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0};
        vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0};
        vecs[3]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0};
        vecs[4]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0};
        vecs[5]  = '{8'd7,   8'd0,   8'hFF, 8'h07, 1'b1};
        vecs[6]  = '{8'h80,  8'd1,   8'h80, 8'h00, 1'b0};
        vecs[7]  = '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0};
        vecs[8]  = '{8'hFF,  8'd2,   8'h00, 8'hFF, 1'b0};
        vecs[9]  = '{8'h80,  8'd0,   8'hFF, 8'h80, 1'b1};
        vecs[10] = '{8'd127, 8'd1,   8'h7F, 8'h00, 1'b0};
`else
        vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0};
        vecs[1]  = '{8'd200, 8'd3,   8'h42, 8'h02, 1'b0};
        vecs[2]  = '{8'd7,   8'd0,   8'hFF, 8'h07, 1'b1};
        vecs[3]  = '{8'd255, 8'd1,   8'hFF, 8'h00, 1'b0};
        vecs[4]  = '{8'd0,   8'd5,   8'h00, 8'h00, 1'b0};
        vecs[5]  = '{8'd5,   8'd9,   8'h00, 8'h05, 1'b0};
        vecs[6]  = '{8'd255, 8'd255, 8'h01, 8'h00, 1'b0};
        vecs[7]  = '{8'd128, 8'd16,  8'h08, 8'h00, 1'b0};
        vecs[8]  = '{8'd254, 8'd255, 8'h00, 8'hFE, 1'b0};
        vecs[9]  = '{8'd255, 8'd2,   8'h7F, 8'h01, 1'b0};
        vecs[10] = '{8'd0,   8'd0,   8'hFF, 8'h00, 1'b1};
`endif

        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_finish", {31'd0, finish}, 32'd0);
        chk("reset_quot",   {24'd0, quotient}, 32'd0);
        chk("reset_rem",    {24'd0, remainder}, 32'd0);
        chk("reset_dz",     {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("idle_no_finish", {31'd0, finish}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), lat, LATENCY);
            chk($sformatf("v%0d_quot", i), {24'd0, quotient}, {24'd0, vecs[i].q});
            chk($sformatf("v%0d_rem", i),  {24'd0, remainder}, {24'd0, vecs[i].r});
            chk($sformatf("v%0d_dz", i),   {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
        end

        // DONE holds its results with no start
        q0 = quotient;
        r0 = remainder;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_finish", {31'd0, finish}, 32'd1);
        chk("hold_quot", {24'd0, quotient}, {24'd0, vecs[NV-1].q});
        chk("hold_rem",  {24'd0, remainder}, {24'd0, vecs[NV-1].r});
        chk("hold_dz",   {31'd0, div_by_zero}, {31'd0, vecs[NV-1].dz});

        // Restart mid-ITER: 50/5 aborted by 9/4
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_still_high_after_start", {31'd0, finish}, 32'd1);
        @(posedge clk);
        #1 chk("restart_finish_fell", {31'd0, finish}, 32'd0);
        chk("restart_dz_fell", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        do_op(8'd9, 8'd4, lat);
        chk("restart_latency", lat, LATENCY);
        chk("restart_quot", {24'd0, quotient}, 32'h02);
        chk("restart_rem",  {24'd0, remainder}, 32'h01);

        // Reset mid-ITER
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_finish", {31'd0, finish}, 32'd0);
        chk("midrst_quot",   {24'd0, quotient}, 32'd0);
        chk("midrst_rem",    {24'd0, remainder}, 32'd0);
        chk("midrst_dz",     {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk("midrst_stays_idle", {31'd0, finish}, 32'd0);

        // Random nonzero-divisor pairs: reconstruction and remainder bound
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            do_op(a, b, lat);
            recon = quotient * b + remainder;
`ifdef DIVIDER_SIGNED_EN
            ia = $signed(a); ib = $signed(b); ir = $signed(remainder);
            iq = ((ir < 0 ? -ir : ir) < (ib < 0 ? -ib : ib)) && (ir == 0 || ((ir < 0) == (ia < 0))) ? 1 : 0;
`else
            ia = a; ib = b; ir = remainder;
            iq = (ir < ib) ? 1 : 0;
`endif
            if (lat != LATENCY || recon != a || iq != 1) begin
                chk($sformatf("rand_%0d_a%0h_b%0h_lat%0d_q%0h_r%0h", k, a, b, lat, quotient, remainder),
                    {24'd0, recon}, {24'd0, a});
                if (recon == a) begin
                    chk($sformatf("rand_%0d_bound_or_latency", k), 32'd0, 32'd1);
                end else begin
                    checks = checks;
                end
            end else begin
                chk($sformatf("rand_%0d_invariant", k), {24'd0, recon}, {24'd0, a});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
